// File: rtl/pipeline_control_sequencer.sv
// rtl/pipeline_control_sequencer.sv - stall/flush/halt sequencer for the 5-stage RV32 pipeline
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   load_use_hazard, branch_taken    hazard and branch requests (ID / EX)
//   dmem_req, dmem_ready             MEM-stage data memory handshake
//   halt_req                         level request to drain and halt
//   pc_write .. mem_wb_flush         PC and stage-register enables / clears
//   halted, mem_timeout              status (registered)
//   stall_cycles, flush_count        saturating performance counters
module pipeline_control_sequencer #(
    parameter int PIPE_DEPTH = 4,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [DW-1:0] DRAIN_DONE = DW'(PIPE_DEPTH);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t          state, state_next;
    logic [WW-1:0]   wait_cnt, wait_next;
    logic [DW-1:0]   drain_cnt, drain_next;
    logic            frozen, lu_stall, br_accept;
    logic            pc_en, ifw_en, iff_en, idw_en, idf_en, exw_en, mwf_en;

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        drain_next = drain_cnt;
        frozen     = 1'b0;
        lu_stall   = 1'b0;
        br_accept  = 1'b0;
        pc_en      = 1'b1;
        ifw_en     = 1'b1;
        iff_en     = 1'b0;
        idw_en     = 1'b1;
        idf_en     = 1'b0;
        exw_en     = 1'b1;
        mwf_en     = 1'b0;

        if (state == HALTED) begin
            pc_en  = 1'b0;
            iff_en = 1'b1;
        end else begin
            // MEM_WAIT freezes until ready regardless of dmem_req
            frozen = !dmem_ready && (state == MEM_WAIT || dmem_req);
            if (frozen) begin
                pc_en  = 1'b0;
                ifw_en = 1'b0;
                idw_en = 1'b0;
                exw_en = 1'b0;
                mwf_en = 1'b1;
            end else if (branch_taken) begin
                br_accept = 1'b1;
                iff_en    = 1'b1;
                idf_en    = 1'b1;
            end else if (load_use_hazard) begin
                lu_stall = 1'b1;
                pc_en    = 1'b0;
                ifw_en   = 1'b0;
                idf_en   = 1'b1;
            end else if (state == DRAIN) begin
                // stop fetching; the IF instruction is refetched on resume
                pc_en  = 1'b0;
                iff_en = 1'b1;
            end
        end

        case (state)
            RUN: begin
                drain_next = '0;
                if (frozen) begin
                    state_next = MEM_WAIT;
                    wait_next  = WW'(1);
                end else if (halt_req) begin
                    state_next = DRAIN;
                end
            end
            MEM_WAIT: begin
                if (frozen) begin
                    if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + WW'(1);
                end else begin
                    wait_next  = '0;
                    state_next = halt_req ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (frozen) begin
                    state_next = MEM_WAIT;
                    wait_next  = WW'(1);
                end else if (!halt_req) begin
                    state_next = RUN;
                end else begin
                    if (!lu_stall) drain_next = drain_cnt + DW'(1);
                    if (drain_next == DRAIN_DONE) state_next = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // a flush clears the stage, so it wins over that stage's write enable
    assign pc_write     = rst_n & pc_en;
    assign if_id_write  = rst_n & ifw_en & !iff_en;
    assign if_id_flush  = rst_n & iff_en;
    assign id_ex_write  = rst_n & idw_en & !idf_en;
    assign id_ex_flush  = rst_n & idf_en;
    assign ex_mem_write = rst_n & exw_en;
    assign mem_wb_flush = rst_n & mwf_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            drain_cnt   <= drain_next;
            halted      <= (state_next == HALTED);
            mem_timeout <= mem_timeout | (wait_next == WAIT_MAX);
            if (!pc_en && state != HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (br_accept && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// tb/tb_pipeline_control_sequencer.sv - randomized and directed checks against a behavioural model
module tb_pipeline_control_sequencer;

    localparam int PD = 4;
    localparam int MW = 16;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu = 1'b0, br = 1'b0, dreq = 1'b0, drdy = 1'b0, hreq = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, halted, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    pipeline_control_sequencer #(.PIPE_DEPTH(PD), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(lu), .branch_taken(br),
        .dmem_req(dreq), .dmem_ready(drdy), .halt_req(hreq),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: the pipeline is either halted, waiting on memory, or running;
    // a pending halt (draining) survives a memory wait
    bit m_halted, m_waiting, m_draining, m_timeout;
    int m_wait, m_drain;
    logic [CW-1:0] m_stalls, m_flushes;

    logic [6:0]  obs_c, exp_c;
    logic [65:0] obs_r, exp_r;

    function automatic bit m_frozen();
        return !m_halted && !drdy && (m_waiting || dreq);
    endfunction

    // {pc, if_id_wr, if_id_fl, id_ex_wr, id_ex_fl, ex_mem_wr, mem_wb_fl}
    function automatic logic [6:0] model_ctrl();
        if (m_halted)                     return 7'b0_0_1_1_0_1_0;
        if (m_frozen())                   return 7'b0_0_0_0_0_0_1;
        if (br)                           return 7'b1_0_1_0_1_1_0;
        if (lu)                           return 7'b0_0_0_0_1_1_0;
        if (m_draining && !m_waiting)     return 7'b0_0_1_1_0_1_0;
        return 7'b1_1_0_1_0_1_0;
    endfunction

    task automatic model_reset();
        m_halted = 0; m_waiting = 0; m_draining = 0; m_timeout = 0;
        m_wait = 0; m_drain = 0; m_stalls = '0; m_flushes = '0;
    endtask

    task automatic model_step();
        bit fz;
        fz = m_frozen();
        if (!m_halted && !exp_c[6] && m_stalls != '1) m_stalls++;
        if (!m_halted && !fz && br && m_flushes != '1) m_flushes++;
        if (m_halted) begin
            if (!hreq) m_halted = 0;
        end else if (fz) begin
            if (!m_waiting) begin
                m_waiting = 1;
                m_wait = 1;
            end else if (m_wait < MW) begin
                m_wait++;
            end
            if (m_wait == MW) m_timeout = 1;
        end else if (m_waiting) begin
            m_waiting = 0;
            m_wait = 0;
            if (hreq) m_draining = 1;
            else begin m_draining = 0; m_drain = 0; end
        end else if (m_draining) begin
            if (!hreq) begin
                m_draining = 0;
                m_drain = 0;
            end else begin
                if (br || !lu) m_drain++;
                if (m_drain == PD) begin
                    m_halted = 1; m_draining = 0; m_drain = 0;
                end
            end
        end else if (hreq) begin
            m_draining = 1;
            m_drain = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {lu, br, dreq, drdy, hreq} = '0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // one clock: drive, sample combinational controls, clock the model, sample registers
    task automatic step(input logic l, input logic b, input logic q, input logic r, input logic h);
        @(negedge clk);
        {lu, br, dreq, drdy, hreq} = {l, b, q, r, h};
        #1;
        obs_c = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};
        exp_c = model_ctrl();
        @(posedge clk);
        model_step();
        #1;
        obs_r = {halted, mem_timeout, stall_cycles, flush_count};
        exp_r = {m_halted, m_timeout, m_stalls, m_flushes};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
             mem_wb_flush, halted, mem_timeout} !== 9'b0 || stall_cycles !== '0 || flush_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pc=%b ifw=%b stall=%0d flush=%0d exp all zero",
                     pc_write, if_id_write, stall_cycles, flush_count);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (obs_c !== 7'b1101010 || obs_r !== 66'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b/%h exp 1101010/0", i, obs_c, obs_r);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        step(1, 0, 0, 1, 0);
        checks++;
        if (obs_c !== exp_c || obs_c !== 7'b0000110) begin
            errors++; $display("FAIL load_use ctrl got %b exp %b", obs_c, exp_c);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (obs_c !== 7'b1101010 || stall_cycles !== 32'd1 || obs_r !== exp_r) begin
            errors++; $display("FAIL load_use after got %b stall=%0d exp 1101010 stall=1", obs_c, stall_cycles);
        end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        step(1, 1, 0, 1, 0);
        checks++;
        if (obs_c !== exp_c || obs_c[6] !== 1'b1 || obs_c[4] !== 1'b1 || obs_c[2] !== 1'b1) begin
            errors++; $display("FAIL branch_lu ctrl got %b exp %b", obs_c, exp_c);
        end
        checks++;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd0 || obs_r !== exp_r) begin
            errors++; $display("FAIL branch_lu counters got flush=%0d stall=%0d exp 1/0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(i == 1, i == 2, 1, i == 3, 0);
            checks++;
            if (obs_c !== exp_c || obs_c[0] !== (i < 3)) begin
                errors++; $display("FAIL mem_wait cyc %0d got %b exp %b", i, obs_c, exp_c);
            end
        end
        checks++;
        if (stall_cycles !== 32'd3 || obs_r !== exp_r) begin
            errors++; $display("FAIL mem_wait stall got %0d exp 3", stall_cycles);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (mem_timeout !== (i >= 16) || obs_r !== exp_r || obs_c !== exp_c) begin
                errors++; $display("FAIL timeout wait %0d got to=%b exp %b", i, mem_timeout, (i >= 16));
            end
        end
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (mem_timeout !== 1'b1 || obs_c !== 7'b1101010) begin
            errors++; $display("FAIL timeout sticky got to=%b ctrl=%b exp 1/1101010", mem_timeout, obs_c);
        end
        step(0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_timeout !== 1'b0 || mem_wb_flush !== 1'b0) begin
            errors++; $display("FAIL timeout reset got to=%b mwf=%b exp 0/0", mem_timeout, mem_wb_flush);
        end
        do_reset();
    endtask

    task automatic test_halt_drain();
        do_reset();
        step(0, 0, 0, 1, 1);
        for (int i = 1; i <= 5; i++) begin
            step(i == 2, 0, 0, 1, 1);
            checks++;
            if (halted !== (i == 5) || obs_c !== exp_c || obs_r !== exp_r) begin
                errors++; $display("FAIL drain cyc %0d got halted=%b ctrl=%b exp %b/%b", i, halted, obs_c, (i == 5), exp_c);
            end
        end
        step(0, 0, 0, 1, 1);
        checks++;
        if (obs_c !== 7'b0011010 || halted !== 1'b1) begin
            errors++; $display("FAIL halted ctrl got %b h=%b exp 0011010/1", obs_c, halted);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (halted !== 1'b0 || obs_r !== exp_r) begin
            errors++; $display("FAIL resume halted got %b exp 0", halted);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (obs_c[6] !== 1'b1) begin
            errors++; $display("FAIL resume pc got %b exp 1", obs_c[6]);
        end
    endtask

    task automatic test_random();
        logic h;
        do_reset();
        h = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 6) h = ~h;
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 55, h);
            checks++;
            if (obs_c !== exp_c || obs_r !== exp_r) begin
                errors++;
                $display("FAIL random cyc %0d ctrl got %b exp %b regs got %h exp %h", i, obs_c, exp_c, obs_r, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
